// File: rtl/screen_denormalizer.sv
// Screen-space to view-plane inverse mapping: one vertex per cycle through a
// shared multiplier pair, three compute cycles per triangle.
package screen_denormalizer_pkg;
   typedef struct packed {
      logic signed [31:0] x;
      logic signed [31:0] y;
      logic signed [31:0] z;
   } vec3_t;

   typedef struct packed {
      vec3_t       pos;
      logic [31:0] color;
      logic [15:0] attr;
   } vertex_t;

   typedef struct packed {
      vertex_t [2:0] v;
      logic [15:0]   tri_id;
   } triangle_t;
endpackage

module screen_denormalizer
   import screen_denormalizer_pkg::*;
#(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240
) (
   input  logic      clk,
   input  logic      rst,
   input  triangle_t triangle,
   input  logic      in_valid,
   output logic      in_ready,
   output triangle_t out_triangle,
   output logic      out_valid,
   input  logic      out_ready,
   output logic      busy
);
   localparam int SCALE             = 200;
   localparam int HALF_WIDTH        = WIDTH / 2;
   localparam int HALF_HEIGHT       = HEIGHT / 2;
   localparam int INV_FACTOR_Q16_16 = (SCALE << 16) / HALF_HEIGHT;

   localparam logic signed [31:0] X_CENTRE = 32'(HALF_WIDTH * 65536);
   localparam logic signed [31:0] Y_CENTRE = 32'(HALF_HEIGHT * 65536);
   localparam logic signed [63:0] INV64    = 64'(INV_FACTOR_Q16_16);
   localparam logic signed [63:0] HALF_LSB = 64'sd32768;

   typedef enum logic [2:0] {IDLE, V0, V1, V2, DONE} state_t;

   state_t    state_q, state_d;
   triangle_t work_q;
   logic      load;
   logic      wr;
   logic [1:0] idx;

   vertex_t            vtx_in, vtx_out;
   logic signed [31:0] dx, dy;
   logic signed [63:0] dx64, dy64, prod_x, prod_y, rnd_x, rnd_y;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      wr      = 1'b0;
      idx     = 2'd0;
      unique case (state_q)
         IDLE: if (in_valid) begin
            load    = 1'b1;
            state_d = V0;
         end
         V0: begin
            wr      = 1'b1;
            idx     = 2'd0;
            state_d = V1;
         end
         V1: begin
            wr      = 1'b1;
            idx     = 2'd1;
            state_d = V2;
         end
         V2: begin
            wr      = 1'b1;
            idx     = 2'd2;
            state_d = DONE;
         end
         DONE: if (out_ready) begin
            if (in_valid) begin
               load    = 1'b1;
               state_d = V0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);

   // Shared datapath: the vertex selected by the current state is the only
   // one fed to the multipliers this cycle.
   assign vtx_in = work_q.v[idx];
   assign dx     = vtx_in.pos.x - X_CENTRE;
   assign dy     = vtx_in.pos.y - Y_CENTRE;
   assign dx64   = {{32{dx[31]}}, dx};
   assign dy64   = {{32{dy[31]}}, dy};
   assign prod_x = dx64 * INV64;
   assign prod_y = dy64 * INV64;
   assign rnd_x  = (prod_x + HALF_LSB) >>> 16;
   assign rnd_y  = (prod_y + HALF_LSB) >>> 16;

   // x mirrors after rounding; all results wrap rather than saturate.
   always_comb begin
      vtx_out       = vtx_in;
      vtx_out.pos.x = 32'd0 - rnd_x[31:0];
      vtx_out.pos.y = rnd_y[31:0];
      vtx_out.pos.z = 32'd0 - vtx_in.pos.z;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work_q       <= '0;
         out_triangle <= '0;
      end else begin
         if (load) work_q <= triangle;
         if (wr) begin
            out_triangle.v[idx] <= vtx_out;
            if (state_q == V0) out_triangle.tri_id <= work_q.tri_id;
         end
      end
   end
endmodule

// File: tb/tb_screen_denormalizer.sv
// Directed-vector bench for screen_denormalizer with hand-computed results.
module tb_screen_denormalizer;
   import screen_denormalizer_pkg::*;

   logic      clk = 1'b0;
   logic      rst = 1'b1;
   triangle_t triangle = '0;
   logic      in_valid = 1'b0;
   logic      in_ready;
   triangle_t out_triangle;
   logic      out_valid;
   logic      out_ready = 1'b0;
   logic      busy;

   int n_chk  = 0;
   int n_fail = 0;

   screen_denormalizer #(.WIDTH(320), .HEIGHT(240)) dut (
      .clk(clk), .rst(rst), .triangle(triangle), .in_valid(in_valid),
      .in_ready(in_ready), .out_triangle(out_triangle), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic vertex_t mkv(input int x, input int y, input int z,
                                   input logic [31:0] c, input logic [15:0] a);
      vertex_t v;
      v.pos.x = x; v.pos.y = y; v.pos.z = z; v.color = c; v.attr = a;
      return v;
   endfunction

   function automatic triangle_t mkt(input vertex_t a, input vertex_t b,
                                     input vertex_t c, input logic [15:0] id);
      triangle_t t;
      t.v[0] = a; t.v[1] = b; t.v[2] = c; t.tri_id = id;
      return t;
   endfunction

   // Single triangle, out_ready withheld for 'hold' cycles after out_valid.
   task automatic run_one(input triangle_t t, input triangle_t e, input int hold, input string tag);
      int lat;
      triangle  = t;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      chk({tag, ".in_ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      triangle = '1;
      lat = 0;
      while (!out_valid && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".latency"}, lat, 3);
      chk({tag, ".tri"}, out_triangle, e);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, ".hold_tri"}, out_triangle, e);
         chk({tag, ".hold_valid"}, out_valid, 1);
         chk({tag, ".hold_in_ready"}, in_ready, 0);
         chk({tag, ".hold_busy"}, busy, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".idle_busy"}, busy, 0);
      chk({tag, ".idle_valid"}, out_valid, 0);
   endtask

   // Fixed-point constants (Q16.16)
   localparam int X160 = 32'h00A00000, Y120 = 32'h00780000;
   localparam int X170 = 32'h00AA0000, Y130 = 32'h00820000;
   localparam int X150 = 32'h00960000, Y110 = 32'h006E0000;
   localparam int Z5   = 327680;
   localparam int ZMIN = 32'h80000000;

   triangle_t tin [4];
   triangle_t texp[4];

   initial begin
      vertex_t c0, c1, c2, o_in, o_ex, n_in, n_ex, r_in, r_ex, w_in, w_ex;
      triangle_t t, e;
      int acc_cyc[4];
      int n_acc, n_out, cyc;

      c0   = mkv(X160, Y120, 0, 32'hFF0000FF, 16'h0001);
      c1   = mkv(X160, Y120, 0, 32'h00FF00FF, 16'h0002);
      c2   = mkv(X160, Y120, 0, 32'h0000FFFF, 16'h0003);
      o_in = mkv(X170, Y130, Z5, 32'h11111111, 16'h0A0A);
      o_ex = mkv(-1092260, 1092260, -Z5, 32'h11111111, 16'h0A0A);
      n_in = mkv(X150, Y110, -Z5, 32'h22222222, 16'h0B0B);
      n_ex = mkv(1092260, -1092260, Z5, 32'h22222222, 16'h0B0B);
      r_in = mkv(32'h00A00001, 32'h0077FFFF, 1, 32'h33333333, 16'h0C0C);
      r_ex = mkv(-2, -2, -1, 32'h33333333, 16'h0C0C);
      w_in = mkv(0, Y120, ZMIN, 32'h44444444, 16'h0D0D);
      w_ex = mkv(17476160, 0, ZMIN, 32'h44444444, 16'h0D0D);

      // Reset state
      #2;
      chk("rst.out_valid", out_valid, 0);
      chk("rst.in_ready", in_ready, 1);
      chk("rst.busy", busy, 0);
      chk("rst.out_triangle", out_triangle, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Centre point: everything maps to origin, attributes pass through
      t = mkt(c0, c1, c2, 16'hC0DE);
      e = mkt(mkv(0, 0, 0, 32'hFF0000FF, 16'h0001), mkv(0, 0, 0, 32'h00FF00FF, 16'h0002),
              mkv(0, 0, 0, 32'h0000FFFF, 16'h0003), 16'hC0DE);
      run_one(t, e, 0, "centre");

      // Offset / negative offset / rounding, with 10 cycles of backpressure
      run_one(mkt(o_in, n_in, r_in, 16'h0BAD), mkt(o_ex, n_ex, r_ex, 16'h0BAD), 10, "offset_bp");

      // Back-to-back with in_valid and out_ready held high
      tin[0] = mkt(o_in, c0, n_in, 16'h1000); texp[0] = mkt(o_ex, e.v[0], n_ex, 16'h1000);
      tin[1] = mkt(r_in, o_in, w_in, 16'h1001); texp[1] = mkt(r_ex, o_ex, w_ex, 16'h1001);
      tin[2] = mkt(w_in, w_in, r_in, 16'h1002); texp[2] = mkt(w_ex, w_ex, r_ex, 16'h1002);
      tin[3] = mkt(n_in, r_in, o_in, 16'h1003); texp[3] = mkt(n_ex, r_ex, o_ex, 16'h1003);
      n_acc = 0; n_out = 0;
      triangle  = tin[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (cyc = 0; cyc < 40 && n_out < 4; cyc++) begin
         logic acc;
         acc = in_valid && in_ready;
         if (acc) acc_cyc[n_acc] = cyc;
         if (out_valid && out_ready) begin
            chk("b2b.tri", out_triangle, texp[n_out]);
            n_out++;
         end
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            if (n_acc < 4) triangle = tin[n_acc];
            else begin
               in_valid = 1'b0;
               triangle = '0;
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("b2b.n_out", n_out, 4);
      chk("b2b.n_acc", n_acc, 4);
      for (int i = 1; i < 4; i++)
         if (i < n_acc) chk("b2b.spacing", acc_cyc[i] - acc_cyc[i-1], 4);
      chk("b2b.idle_busy", busy, 0);

      // Reset during V1
      triangle = mkt(o_in, n_in, c0, 16'hDEAD);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid.busy_pre", busy, 1);
      rst = 1'b1;
      #1;
      chk("mid.out_valid", out_valid, 0);
      chk("mid.out_triangle", out_triangle, 0);
      chk("mid.in_ready", in_ready, 1);
      chk("mid.busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Wrap: z = -2^31 stays, x = 0 maps to +17476160
      run_one(mkt(w_in, o_in, c1, 16'hFACE),
              mkt(w_ex, o_ex, mkv(0, 0, 0, 32'h00FF00FF, 16'h0002), 16'hFACE), 0, "wrap");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/screen_denormalizer.md
# screen_denormalizer

Inverse of the screen-space mapping stage. It accepts a `triangle_t` whose vertex positions are in screen pixels (Q16.16) and returns the triangle in view-plane units, with screen x mirrored back, y re-centred and z negated. Use it for picking and readback, where raster-space triangles must be compared against transformer output. It processes one vertex per cycle through a single shared multiplier pair, so a triangle takes three compute cycles.

## Interface
Parameters:
- `WIDTH`, 320: screen width in pixels.
- `HEIGHT`, 240: screen height in pixels.

Derived constants (localparams):
- `SCALE` = 200
- `HALF_WIDTH` = WIDTH/2
- `HALF_HEIGHT` = HEIGHT/2
- `INV_FACTOR_Q16_16` = (SCALE<<16)/HALF_HEIGHT, truncated. This is 109226 at the defaults.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `triangle`  in  `triangle_t`  input triangle, screen space.
- `in_valid`  in  1  input triangle valid.
- `in_ready`  out  1  block can accept a triangle this cycle.
- `out_triangle`  out  `triangle_t`  denormalized triangle.
- `out_valid`  out  1  `out_triangle` valid.
- `out_ready`  in  1  downstream accepts.
- `busy`  out  1  high whenever the block is not idle.

## Operation
FSM states: IDLE, V0, V1, V2, DONE.
- IDLE: on `in_valid && in_ready`, latch `triangle` into the working register and go to V0.
- V0, V1, V2: compute vertex k (k = 0, 1, 2) and write it into `out_triangle` vertex k, then advance. V2 goes to DONE.
- DONE: `out_valid` = 1. When `out_ready` = 1:
  - with a simultaneous input handshake, latch the new triangle and go to V0;
  - otherwise go to IDLE.

`in_ready` = (state == IDLE) || (state == DONE && `out_ready`). This is combinational.

`busy` = (state != IDLE).

Per-vertex arithmetic, all signed with 64-bit intermediates:
- dx = pos.x − (HALF_WIDTH<<16); dy = pos.y − (HALF_HEIGHT<<16). Both are 32-bit Q16.16.
- x_out = −( ((dx·INV_FACTOR) + 2^15) >>> 16 ), truncated to 32 bits.
- y_out = ((dy·INV_FACTOR) + 2^15) >>> 16, truncated to 32 bits.
- z_out = −pos.z, in two's complement, so −(−2^31) wraps to −2^31.
- All non-position fields of each vertex, and all triangle-level fields, copy unchanged from the latched input.
- Results are not saturated. Overflow beyond 32 bits wraps.
- Rounding is round-half-up in the two's-complement sense. For x, negation is applied after rounding.

Once latched, changes on `triangle` have no effect on the triangle in flight.

While `out_valid` = 1 and `out_ready` = 0, `out_triangle` and `out_valid` are held stable.

Reset, asynchronous at any point including mid-triangle:
- state = IDLE, `out_valid` = 0, `out_triangle` = '0, working register = '0.
- Consequently `in_ready` = 1 and `busy` = 0.
- Any partial triangle is discarded.

## Timing
- Accept edge E0 (handshake in IDLE). Vertex 0 is written at E1, vertex 1 at E2, vertex 2 at E3.
- `out_valid` goes high after E3, so latency is 3 cycles from accept to valid.
- Output handshake at edge Ed. If a new input is accepted at the same edge, `out_valid` falls after Ed and rises again after Ed+3.
- Sustained throughput is one triangle per 4 cycles with `out_ready` held high.
- `out_triangle` vertices may update individually during V0–V2. Consumers sample only when `out_valid` = 1.
- No combinational path from `triangle` or `in_valid` to any output.
- The only combinational path is from `out_ready` to `in_ready`.

## Test plan
- Centre point: all vertices pos = (160.0, 120.0, 0), i.e. x = 0x00A00000, y = 0x00780000. Response: all vertices (0, 0, 0); `out_valid` 3 cycles after accept; colour/attribute fields unchanged.
- Offset point: pos = (170.0, 130.0, 5.0), i.e. 655360 above centre on each of x and y, z = 327680. Response: x = −1092260, y = 1092260, z = −327680.
- Backpressure: hold `out_ready` = 0 for 10 cycles after `out_valid`. Response: output stable, `in_ready` = 0, `busy` = 1. Then one-cycle `out_ready` → IDLE.
- Back-to-back: `in_valid` and `out_ready` held high with 4 distinct triangles. Response: accepts spaced exactly 4 cycles apart; outputs in order and correct.
- Reset mid-operation: assert `rst` during V1. Response: immediately `out_valid` = 0, `out_triangle` = 0, `in_ready` = 1, `busy` = 0. The next triangle after release is processed correctly.
- Wrap: pos.z = 0x80000000. Response: z_out = 0x80000000. pos.x = 0 gives x_out = +(160·INV rounded) = 17476160.
